// File: rtl/etc2_block_fetch.sv
// etc2_block_fetch: packs the compressed byte stream into 64-bit ETC2 blocks,
// tags each with punch flag and (x,y), and buffers them in a 2-deep FIFO.
//
// state    | meaning
// IDLE     | waiting for start; no bytes taken
// ASSEMBLE | accepting bytes, assembling and pushing blocks
// DRAIN    | last block pushed; waiting for the FIFO to empty
module etc2_block_fetch #(
   parameter int W_BLKS = 64,
   parameter int H_BLKS = 64,
   parameter int XW     = 6,
   parameter int YW     = 6
) (
   input  logic          sclk,
   input  logic          rsrt,
   input  logic          start,
   input  logic          cfg_punch,
   input  logic [7:0]    byte_in,
   input  logic          byte_rts,
   output logic          byte_rtr,
   output logic [63:0]   blk_data,
   output logic          blk_flags,
   output logic [XW-1:0] blk_x,
   output logic [YW-1:0] blk_y,
   output logic          blk_rts,
   input  logic          blk_rdy,
   output logic          busy,
   output logic          frame_done
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSEMBLE = 2'd1,
      DRAIN    = 2'd2
   } state_t;

   localparam logic [XW-1:0] X_LAST = XW'(W_BLKS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(H_BLKS - 1);

   state_t          state;
   state_t          state_nxt;
   logic            frame_flag;
   logic [2:0]      byte_cnt;
   logic [55:0]     asm_sr;
   logic [XW-1:0]   cnt_x;
   logic [YW-1:0]   cnt_y;
   logic            pend_valid;
   logic            pend_flag;
   logic [63:0]     pend_data;
   logic [XW-1:0]   pend_x;
   logic [YW-1:0]   pend_y;
   logic [1:0]      fifo_count;
   logic            byte_take;
   logic            blk_done;
   logic            last_blk;
   logic            pop;
   logic            head_load;

   // FIFO entry 0 is the registered head, entry 1 is the in-flight push stage
   assign fifo_count = {1'b0, pend_valid} + {1'b0, blk_rts};
   assign byte_take  = byte_rts && byte_rtr;
   assign blk_done   = byte_take && (byte_cnt == 3'd7);
   assign last_blk   = (cnt_x == X_LAST) && (cnt_y == Y_LAST);
   assign pop        = blk_rts && blk_rdy;
   assign head_load  = pend_valid && (!blk_rts || pop);

   always_ff @(posedge sclk or posedge rsrt) begin
      if (rsrt) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = ASSEMBLE;
         ASSEMBLE: if (blk_done && last_blk) state_nxt = DRAIN;
         DRAIN:    if (fifo_count == 2'd0) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      byte_rtr   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         ASSEMBLE: begin
            byte_rtr = (fifo_count < 2'd2);
            busy     = 1'b1;
         end
         DRAIN: begin
            busy       = 1'b1;
            frame_done = (fifo_count == 2'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge sclk or posedge rsrt) begin
      if (rsrt) begin
         frame_flag <= 1'b0;
         byte_cnt   <= '0;
         asm_sr     <= '0;
         cnt_x      <= '0;
         cnt_y      <= '0;
         pend_valid <= 1'b0;
         pend_flag  <= 1'b0;
         pend_data  <= '0;
         pend_x     <= '0;
         pend_y     <= '0;
         blk_data   <= '0;
         blk_flags  <= 1'b0;
         blk_x      <= '0;
         blk_y      <= '0;
         blk_rts    <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            frame_flag <= cfg_punch;
            byte_cnt   <= '0;
            cnt_x      <= '0;
            cnt_y      <= '0;
         end

         if (byte_take) begin
            asm_sr   <= {asm_sr[47:0], byte_in};
            byte_cnt <= byte_cnt + 3'd1;
         end

         if (blk_done) begin
            pend_data <= {asm_sr, byte_in};
            pend_flag <= frame_flag;
            pend_x    <= cnt_x;
            pend_y    <= cnt_y;
            if (cnt_x == X_LAST) begin
               cnt_x <= '0;
               cnt_y <= (cnt_y == Y_LAST) ? '0 : cnt_y + YW'(1);
            end else begin
               cnt_x <= cnt_x + XW'(1);
            end
         end

         // a new push may land in the stage while its old content moves to head
         if (blk_done) begin
            pend_valid <= 1'b1;
         end else if (head_load) begin
            pend_valid <= 1'b0;
         end

         if (head_load) begin
            blk_data  <= pend_data;
            blk_flags <= pend_flag;
            blk_x     <= pend_x;
            blk_y     <= pend_y;
            blk_rts   <= 1'b1;
         end else if (pop) begin
            blk_rts <= 1'b0;
         end
      end
   end
endmodule
